shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 SHALL have port isSigned, input, 1 bit: 1 = MULT (two's complement), 0 = MULTU.
REQ-005 SHALL have port inA, input, 32 bits: multiplicand, captured on the accepted start edge.
REQ-006 SHALL have port inB, input, 32 bits: multiplier, captured on the accepted start edge.
REQ-007 SHALL have port hi, output, 32 bits: product bits [63:32].
REQ-008 SHALL have port lo, output, 32 bits: product bits [31:0].
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.

Function
REQ-011 SHALL contain exactly one thirtytwoBitFullAdder instance, time-shared by all arithmetic states; no other adder or subtractor.
REQ-012 SHALL implement states IDLE, NEG_A, NEG_B, MUL, FIX_LO, FIX_HI, DONE.
REQ-013 SHALL in IDLE with start=1 capture inA, inB and isSigned; go to NEG_A if isSigned=1, else clear hi, load lo=inB, and go to MUL.
REQ-014 SHALL ignore start in every state other than IDLE, including DONE; captured operands stay unchanged.
REQ-015 SHALL in NEG_A, if the captured A[31]=1, replace the multiplicand with ~A + 0 + carryIn=1 through the shared adder; otherwise hold it. Record sign = A[31] ^ B[31]. Go to NEG_B.
REQ-016 SHALL in NEG_B negate B the same way if B[31]=1, load the result into lo, clear hi, and go to MUL.
REQ-017 SHALL spend exactly 32 cycles in MUL, counted by a 5-bit counter cleared on entry; leave after count 31.
REQ-018 SHALL in each MUL cycle, if lo[0]=1, form {c, s} = hi + mcand with carryIn=0 and load {hi, lo} <= {c, s, lo[31:1]}; otherwise load {hi, lo} <= {0, hi, lo[31:1]}.
REQ-019 SHALL leave MUL to FIX_LO if the captured isSigned=1, else to DONE.
REQ-020 SHALL in FIX_LO, if sign=1, load lo <= ~lo + 1 and store the adder carryOut into a 1-bit register; if sign=0, hold lo and store carry=0. Go to FIX_HI.
REQ-021 SHALL in FIX_HI, if sign=1, load hi <= ~hi + 0 + stored carry; otherwise hold hi. Go to DONE.
REQ-022 SHALL in DONE assert done=1 for one cycle and return to IDLE.
REQ-023 SHALL hold hi and lo from DONE until the next accepted start.
REQ-024 SHALL leave hi and lo undefined for checking while busy=1.
REQ-025 SHALL have these latencies, measured from the accepted start edge to the done=1 cycle: 33 cycles for unsigned, 37 cycles for signed.
REQ-026 SHALL treat the magnitude of 0x80000000 as 2^31 unsigned, so the negation result 0x80000000 is correct.
REQ-027 SHALL produce a 0 product with hi=lo=0 when either operand is 0, including in signed mode with sign=1.

Reset
REQ-028 SHALL, with reset=1 at a clock edge, go to IDLE and clear hi, lo, busy, done, the counter, the carry register, sign and captured operands to 0.
REQ-029 SHALL let reset take priority over start and over any state transition.
REQ-030 SHALL abort any in-progress operation on reset mid-operation with no done pulse; a start in the cycle after reset deasserts SHALL be accepted normally.

Verification
REQ-031 Bench SHALL cover unsigned 3 x 5 -> hi=0x00000000, lo=0x0000000F, done exactly 33 cycles after start.
REQ-032 Bench SHALL cover unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Bench SHALL cover signed -3 (0xFFFFFFFD) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, done exactly 37 cycles after start.
REQ-034 Bench SHALL cover signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-035 Bench SHALL cover signed 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-036 Bench SHALL pulse start again during MUL (ignored, result unchanged), then assert reset at MUL cycle 10 -> next cycle busy=0, done=0, hi=lo=0; a following 7 x 6 unsigned -> lo=0x0000002A.
REQ-037 Bench SHALL hold start=1 continuously -> back-to-back operations with exactly one IDLE cycle between each DONE and the next MUL or NEG_A.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Iterative 32x32 -> 64 shift-and-add multiplier (MULT / MULTU).
// Signed operands are converted to magnitudes up front, multiplied unsigned
// over 32 cycles, then the 64-bit product is negated in two halves when the
// operand signs differ. Every arithmetic step goes through one shared
// 32-bit ripple adder whose operands are selected by the current state.

module thirtytwoBitFullAdder (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        carry_i,
   output logic [31:0] sum_o,
   output logic        carry_o
);

   logic [32:0] carry_chain;

   assign carry_chain[0] = carry_i;

   // Plain ripple-carry chain, one full adder per bit.
   for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      assign sum_o[gi]           = a_i[gi] ^ b_i[gi] ^ carry_chain[gi];
      assign carry_chain[gi + 1] = (a_i[gi] & b_i[gi]) |
                                   (carry_chain[gi] & (a_i[gi] ^ b_i[gi]));
   end

   assign carry_o = carry_chain[32];

endmodule

module shift_add_multiplier (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        isSigned,
   input  logic [31:0] inA,
   input  logic [31:0] inB,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NEG_A,
      S_NEG_B,
      S_MUL,
      S_FIX_LO,
      S_FIX_HI,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [31:0] mcand_q;     // multiplicand (magnitude after NEG_A)
   logic [31:0] mplier_q;    // captured multiplier, kept as received
   logic        signed_q;    // captured isSigned
   logic        sign_q;      // product must be negated
   logic        carry_q;     // carry from low-half negation into high half
   logic [4:0]  count_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        busy_q;
   logic        done_q;

   logic [31:0] add_a_d;
   logic [31:0] add_b_d;
   logic        add_cin_d;
   logic [31:0] add_sum;
   logic        add_cout;

   thirtytwoBitFullAdder u_adder (
      .a_i     (add_a_d),
      .b_i     (add_b_d),
      .carry_i (add_cin_d),
      .sum_o   (add_sum),
      .carry_o (add_cout)
   );

   // Route the shared adder: negations are ~x + 0 + cin, MUL accumulates hi + mcand.
   always_comb begin
      add_a_d   = 32'd0;
      add_b_d   = 32'd0;
      add_cin_d = 1'b0;
      case (state_q)
         S_NEG_A: begin
            add_a_d   = ~mcand_q;
            add_cin_d = 1'b1;
         end
         S_NEG_B: begin
            add_a_d   = ~mplier_q;
            add_cin_d = 1'b1;
         end
         S_MUL: begin
            add_a_d = hi_q;
            add_b_d = mcand_q;
         end
         S_FIX_LO: begin
            add_a_d   = ~lo_q;
            add_cin_d = 1'b1;
         end
         S_FIX_HI: begin
            add_a_d   = ~hi_q;
            add_cin_d = carry_q;
         end
         default: begin
            add_a_d   = 32'd0;
         end
      endcase
   end

   // Control FSM and datapath registers; busy/done are registered with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         signed_q <= 1'b0;
         sign_q   <= 1'b0;
         carry_q  <= 1'b0;
         count_q  <= 5'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mcand_q  <= inA;
                  mplier_q <= inB;
                  signed_q <= isSigned;
                  sign_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  if (isSigned) begin
                     state_q <= S_NEG_A;
                  end else begin
                     hi_q    <= 32'd0;
                     lo_q    <= inB;
                     count_q <= 5'd0;
                     state_q <= S_MUL;
                  end
               end
            end
            S_NEG_A: begin
               if (mcand_q[31]) begin
                  mcand_q <= add_sum;
               end
               sign_q  <= mcand_q[31] ^ mplier_q[31];
               state_q <= S_NEG_B;
            end
            S_NEG_B: begin
               lo_q    <= mplier_q[31] ? add_sum : mplier_q;
               hi_q    <= 32'd0;
               count_q <= 5'd0;
               state_q <= S_MUL;
            end
            S_MUL: begin
               // The adder's carry-out becomes hi[31] after the right shift.
               if (lo_q[0]) begin
                  {hi_q, lo_q} <= {add_cout, add_sum, lo_q[31:1]};
               end else begin
                  {hi_q, lo_q} <= {1'b0, hi_q, lo_q[31:1]};
               end
               count_q <= count_q + 5'd1;
               if (count_q == 5'd31) begin
                  if (signed_q) begin
                     state_q <= S_FIX_LO;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_FIX_LO: begin
               if (sign_q) begin
                  lo_q    <= add_sum;
                  carry_q <= add_cout;
               end else begin
                  carry_q <= 1'b0;
               end
               state_q <= S_FIX_HI;
            end
            S_FIX_HI: begin
               if (sign_q) begin
                  hi_q <= add_sum;
               end
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed corner products,
// randomized products against a 64-bit arithmetic reference, start-ignore
// and mid-operation reset, and back-to-back operation spacing.

module tb_shift_add_multiplier;

   logic        clk;
   logic        reset;
   logic        start;
   logic        isSigned;
   logic [31:0] inA;
   logic [31:0] inB;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   shift_add_multiplier dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .isSigned (isSigned),
      .inA      (inA),
      .inB      (inB),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference product from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_product(input logic s, input logic [31:0] a,
                                               input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] ua;
      logic [63:0] ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (s) return 64'(sa * sb);
      return ua * ub;
   endfunction

   // Drive a request at the current (negedge) time; accepted at the next posedge.
   task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
      start    = 1'b1;
      isSigned = s;
      inA      = a;
      inB      = b;
   endtask

   // Wait for done, counting negedges after the start edge; lat=0 means timeout.
   task automatic wait_done(output int lat, output logic [31:0] h, output logic [31:0] l);
      lat = 0;
      h   = 32'd0;
      l   = 32'd0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (done === 1'b1) begin
            lat = n;
            h   = hi;
            l   = lo;
            break;
         end
      end
   endtask

   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] h, output logic [31:0] l);
      @(negedge clk);
      launch(s, a, b);
      wait_done(lat, h, l);
   endtask

   // Reset holds everything at zero even with start asserted.
   task automatic test_reset();
      reset = 1'b1;
      launch(1'b0, 32'd5, 32'd7);
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero",
                  busy, done, hi, lo);
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b, required 0", busy);
      end
      $display("test_reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
   endtask

   // Directed products including the 0x80000000 corners and exact latencies.
   task automatic test_directed();
      logic [31:0] ta [5];
      logic [31:0] tb [5];
      logic        ts [5];
      logic [31:0] ehi[5];
      logic [31:0] elo[5];
      int          lat;
      logic [31:0] h;
      logic [31:0] l;
      ta  = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h80000000};
      tb  = '{32'd5, 32'hFFFFFFFF, 32'd5,        32'h80000000, 32'd1};
      ts  = '{1'b0,  1'b0,         1'b1,         1'b1,         1'b1};
      ehi = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF};
      elo = '{32'hF, 32'h00000001, 32'hFFFFFFF1, 32'h00000000, 32'h80000000};
      for (int i = 0; i < 5; i++) begin
         run_op(ts[i], ta[i], tb[i], lat, h, l);
         checks++;
         if (lat !== (ts[i] ? 37 : 33)) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d",
                     i, lat, ts[i] ? 37 : 33);
         end
         checks++;
         if ({h, l} !== {ehi[i], elo[i]}) begin
            errors++;
            $display("FAIL directed_product[%0d]: got hi=%h lo=%h, required hi=%h lo=%h",
                     i, h, l, ehi[i], elo[i]);
         end
         // done is a single-cycle pulse and the result holds while idle.
         repeat (2) @(negedge clk);
         checks++;
         if ({done, busy, hi, lo} !== {1'b0, 1'b0, ehi[i], elo[i]}) begin
            errors++;
            $display("FAIL directed_hold[%0d]: done=%b busy=%b hi=%h lo=%h, required 0 0 %h %h",
                     i, done, busy, hi, lo, ehi[i], elo[i]);
         end
         $display("test_directed[%0d]: s=%b a=%h b=%h -> hi=%h lo=%h lat=%0d",
                  i, ts[i], ta[i], tb[i], h, l, lat);
      end
   endtask

   // Either operand zero gives a zero product, including signed with differing signs.
   task automatic test_zero();
      logic [31:0] za [3];
      logic [31:0] zb [3];
      logic        zs [3];
      int          lat;
      logic [31:0] h;
      logic [31:0] l;
      za = '{32'd0,        32'hFFFFFFFB, 32'd0};
      zb = '{32'hFFFFFFFB, 32'd0,        32'hDEADBEEF};
      zs = '{1'b1,         1'b1,         1'b0};
      for (int i = 0; i < 3; i++) begin
         run_op(zs[i], za[i], zb[i], lat, h, l);
         checks++;
         if ({h, l} !== 64'd0 || lat == 0) begin
            errors++;
            $display("FAIL zero_product[%0d]: got hi=%h lo=%h lat=%0d, required 0 0",
                     i, h, l, lat);
         end
         $display("test_zero[%0d]: s=%b a=%h b=%h -> hi=%h lo=%h", i, zs[i], za[i], zb[i], h, l);
      end
   endtask

   // Random operands with a bias towards edge values.
   task automatic test_random();
      logic [31:0] corner [5];
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] exp_p;
      int          lat;
      logic [31:0] h;
      logic [31:0] l;
      corner = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      for (int i = 0; i < 24; i++) begin
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         s = 1'($urandom_range(0, 1));
         exp_p = ref_product(s, a, b);
         run_op(s, a, b, lat, h, l);
         checks++;
         if ({h, l} !== exp_p || lat !== (s ? 37 : 33)) begin
            errors++;
            $display("FAIL random[%0d]: s=%b a=%h b=%h got %h%h lat=%0d, required %h lat=%0d",
                     i, s, a, b, h, l, lat, exp_p, s ? 37 : 33);
         end
         $display("test_random[%0d]: s=%b a=%h b=%h -> %h%h lat=%0d", i, s, a, b, h, l, lat);
      end
   endtask

   // start during MUL is ignored; reset at MUL cycle 10 aborts; next start accepted at once.
   task automatic test_ignore_and_abort();
      int          lat;
      int          early_done;
      logic [31:0] h;
      logic [31:0] l;
      @(negedge clk);
      launch(1'b0, 32'd3, 32'd5);
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (n == 5) launch(1'b1, 32'h12345678, 32'h9ABCDEF0);
         if (n == 6) start = 1'b0;
         if (done === 1'b1) begin
            lat = n;
            h   = hi;
            l   = lo;
            break;
         end
      end
      checks++;
      if (lat !== 33 || {h, l} !== 64'hF) begin
         errors++;
         $display("FAIL ignore_start: got hi=%h lo=%h lat=%0d, required 0 0000000f lat=33",
                  h, l, lat);
      end
      $display("test_ignore: 3x5 with stray start -> hi=%h lo=%h lat=%0d", h, l, lat);

      @(negedge clk);
      launch(1'b0, 32'hABCD0123, 32'h00F0F0F1);
      early_done = 0;
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (done !== 1'b0) early_done++;
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, hi, lo} !== 66'd0 || early_done != 0) begin
         errors++;
         $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h early_done=%0d, required all 0",
                  busy, done, hi, lo, early_done);
      end
      reset = 1'b0;
      launch(1'b0, 32'd7, 32'd6);
      wait_done(lat, h, l);
      checks++;
      if (lat !== 33 || {h, l} !== 64'h2A) begin
         errors++;
         $display("FAIL after_abort: got hi=%h lo=%h lat=%0d, required 0 0000002a lat=33",
                  h, l, lat);
      end
      $display("test_abort: 7x6 after reset -> hi=%h lo=%h lat=%0d", h, l, lat);
   endtask

   // start held high: each DONE is followed by exactly one IDLE cycle.
   task automatic test_back_to_back();
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_p;
      logic        s;
      logic        exp_busy;
      logic        exp_done;
      int          p;
      for (int m = 0; m < 2; m++) begin
         s = 1'(m);
         a = $urandom;
         b = $urandom;
         exp_p = ref_product(s, a, b);
         p = s ? 38 : 34;
         @(negedge clk);
         launch(s, a, b);
         for (int n = 1; n <= 3 * p - 1; n++) begin
            @(negedge clk);
            exp_busy = ((n % p) != 0);
            exp_done = ((n % p) == p - 1);
            checks++;
            if (busy !== exp_busy || done !== exp_done) begin
               errors++;
               $display("FAIL b2b_timing: s=%b cycle %0d busy=%b done=%b, required busy=%b done=%b",
                        s, n, busy, done, exp_busy, exp_done);
            end
            if (exp_done) begin
               checks++;
               if ({hi, lo} !== exp_p) begin
                  errors++;
                  $display("FAIL b2b_product: s=%b cycle %0d got %h%h, required %h",
                           s, n, hi, lo, exp_p);
               end
               $display("test_back_to_back: s=%b a=%h b=%h cycle %0d -> %h%h",
                        s, a, b, n, hi, lo);
            end
            if (n == 3 * p - 1) start = 1'b0;
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      isSigned = 1'b0;
      inA      = 32'd0;
      inB      = 32'd0;
      test_reset();
      test_directed();
      test_zero();
      test_random();
      test_ignore_and_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
